dprintf_4_arbiter: RTL and testbench



---
 rtl/dprintf_arb_pkg.sv | 20 ++
 rtl/dprintf_4_arbiter_if.sv | 20 ++
 rtl/round_robin_pick_4.sv | 23 ++
 rtl/dprintf_4_arbiter.sv | 89 ++++++++
 tb/tb_dprintf_4_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dprintf_arb_pkg.sv
// rtl/dprintf_arb_pkg.sv - shared types and constants for the 4-way dprintf arbiter
package dprintf_arb_pkg;

    localparam int DPRINTF_ARB_NUM_REQ = 4;

    typedef struct packed {
        logic        valid;
        logic [15:0] address;
        logic [63:0] data_0;
        logic [63:0] data_1;
        logic [63:0] data_2;
        logic [63:0] data_3;
    } t_dprintf_req_4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } t_dprintf_arb_state;

endpackage

// File: rtl/dprintf_4_arbiter_if.sv
// rtl/dprintf_4_arbiter_if.sv - downstream dprintf valid/ack bus
interface dprintf_4_arbiter_if;
    logic        req__valid;
    logic [15:0] req__address;
    logic [63:0] req__data_0;
    logic [63:0] req__data_1;
    logic [63:0] req__data_2;
    logic [63:0] req__data_3;
    logic        ack;

    modport master (
        output req__valid, req__address, req__data_0, req__data_1, req__data_2, req__data_3,
        input  ack
    );

    modport slave (
        input  req__valid, req__address, req__data_0, req__data_1, req__data_2, req__data_3,
        output ack
    );
endinterface

// File: rtl/round_robin_pick_4.sv
// rtl/round_robin_pick_4.sv - combinational 4-way round-robin pick
module round_robin_pick_4 (
    input  logic [3:0] eligible,
    input  logic [1:0] last_grant,
    output logic       any,
    output logic [1:0] grant
);
    logic [1:0] idx;

    // Search starts just after the previous winner; the 2-bit add wraps mod 4.
    always_comb begin
        any   = 1'b0;
        grant = 2'd0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!any && eligible[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end
endmodule

// File: rtl/dprintf_4_arbiter.sv
// rtl/dprintf_4_arbiter.sv - round-robin arbiter sharing one dprintf slave among four requesters
module dprintf_4_arbiter
    import dprintf_arb_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 clk__enable,
    input  logic                                 reset,
    input  logic [DPRINTF_ARB_NUM_REQ-1:0]       req_valid,
    input  logic [16*DPRINTF_ARB_NUM_REQ-1:0]    req_address,
    input  logic [256*DPRINTF_ARB_NUM_REQ-1:0]   req_data,
    output logic [DPRINTF_ARB_NUM_REQ-1:0]       req_ack,
    output logic [1:0]                           last_grant,
    dprintf_4_arbiter_if.master                  dprintf
);
    localparam logic [0:0] ST_IDLE    = 1'(IDLE);
    localparam logic [0:0] ST_PRESENT = 1'(PRESENT);

    t_dprintf_req_4                   req_q, req_d;
    logic [DPRINTF_ARB_NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [1:0]                       last_grant_q, last_grant_d;
    logic [0:0]                       state_q, state_d;

    logic [3:0]   eligible;
    logic         any;
    logic [1:0]   grant;
    logic         capture;
    logic [255:0] slice;
    logic [15:0]  addr_sel;

    // A requester whose ack is visible still has valid high; mask it out.
    assign eligible = req_valid & ~req_ack_q;

    round_robin_pick_4 u_pick (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .any        (any),
        .grant      (grant)
    );

    assign capture  = any && ((state_q == ST_IDLE) || dprintf.ack);
    assign slice    = req_data[{grant, 8'd0} +: 256];
    assign addr_sel = req_address[{grant, 4'd0} +: 16];

    always_comb begin
        req_d        = req_q;
        req_ack_d    = '0;
        last_grant_d = last_grant_q;
        state_d      = state_q;
        if (capture) begin
            req_d.valid      = 1'b1;
            req_d.address    = addr_sel;
            req_d.data_0     = slice[255:192];
            req_d.data_1     = slice[191:128];
            req_d.data_2     = slice[127:64];
            req_d.data_3     = slice[63:0];
            req_ack_d[grant] = 1'b1;
            last_grant_d     = grant;
            state_d          = ST_PRESENT;
        end else if ((state_q == ST_PRESENT) && dprintf.ack) begin
            req_d.valid = 1'b0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (clk__enable) begin
            if (reset) begin
                req_q        <= '0;
                req_ack_q    <= '0;
                last_grant_q <= 2'd3;
                state_q      <= ST_IDLE;
            end else begin
                req_q        <= req_d;
                req_ack_q    <= req_ack_d;
                last_grant_q <= last_grant_d;
                state_q      <= state_d;
            end
        end
    end

    assign req_ack              = req_ack_q;
    assign last_grant           = last_grant_q;
    assign dprintf.req__valid   = req_q.valid;
    assign dprintf.req__address = req_q.address;
    assign dprintf.req__data_0  = req_q.data_0;
    assign dprintf.req__data_1  = req_q.data_1;
    assign dprintf.req__data_2  = req_q.data_2;
    assign dprintf.req__data_3  = req_q.data_3;
endmodule

// File: tb/tb_dprintf_4_arbiter.sv
// tb/tb_dprintf_4_arbiter.sv - directed self-checking bench for dprintf_4_arbiter
module tb_dprintf_4_arbiter;
    logic          clk = 1'b0;
    logic          clk__enable;
    logic          reset;
    logic [3:0]    req_valid;
    logic [63:0]   req_address;
    logic [1023:0] req_data;
    logic [3:0]    req_ack;
    logic [1:0]    last_grant;

    int passed = 0;
    int total  = 0;

    dprintf_4_arbiter_if dif ();

    dprintf_4_arbiter dut (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_address (req_address),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .last_grant  (last_grant),
        .dprintf     (dif.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        clk__enable = 1'b1;
        reset       = 1'b1;
        req_valid   = 4'b0000;
        req_address = '0;
        req_data    = '0;
        dif.ack     = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b0;
        chk("rst_valid", 64'(dif.req__valid), 64'd0);
        chk("rst_addr", 64'(dif.req__address), 64'd0);
        chk("rst_data0", dif.req__data_0, 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_last", 64'(last_grant), 64'd3);

        // single request from requester 2, slave stalls 8 cycles
        req_valid = 4'b0100;
        req_address[32 +: 16] = 16'h1234;
        req_data[512+192 +: 64] = 64'h0123456789abcdef;
        req_data[512+0 +: 64]   = 64'hfeedface00000003;
        step();
        chk("t1_valid", 64'(dif.req__valid), 64'd1);
        chk("t1_addr", 64'(dif.req__address), 64'h1234);
        chk("t1_data0", dif.req__data_0, 64'h0123456789abcdef);
        chk("t1_data3", dif.req__data_3, 64'hfeedface00000003);
        chk("t1_ack", 64'(req_ack), 64'b0100);
        chk("t1_last", 64'(last_grant), 64'd2);
        req_valid = 4'b0000;
        for (int c = 0; c < 7; c++) begin
            step();
            chk("t1_hold_valid", 64'(dif.req__valid), 64'd1);
            chk("t1_hold_addr", 64'(dif.req__address), 64'h1234);
            chk("t1_hold_ack", 64'(req_ack), 64'd0);
        end
        dif.ack = 1'b1;
        step();
        chk("t1_done_valid", 64'(dif.req__valid), 64'd0);
        dif.ack = 1'b0;

        // all four from reset, slave acks continuously
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) req_address[16*i +: 16] = 16'(16'h1000 + i);
        req_valid = 4'b1111;
        dif.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_valid", 64'(dif.req__valid), 64'd1);
            chk("t2_ack", 64'(req_ack), 64'(4'b0001 << i));
            chk("t2_addr", 64'(dif.req__address), 64'(16'h1000 + i));
            req_valid[i] = 1'b0;
        end
        step();
        chk("t2_end_valid", 64'(dif.req__valid), 64'd0);

        // round-robin search order from last_grant=1
        req_valid = 4'b0010;
        step();
        chk("t3_setup_last", 64'(last_grant), 64'd1);
        req_valid = 4'b0000;
        dif.ack = 1'b0;
        step();
        req_valid = 4'b0011;
        dif.ack = 1'b1;
        step();
        chk("t3a_ack", 64'(req_ack), 64'b0001);
        chk("t3a_last", 64'(last_grant), 64'd0);
        chk("t3a_addr", 64'(dif.req__address), 64'h1000);
        req_valid = 4'b0000;
        step();
        chk("t3a_idle", 64'(dif.req__valid), 64'd0);
        req_valid = 4'b0010;
        dif.ack = 1'b0;
        step();
        chk("t3b_setup_last", 64'(last_grant), 64'd1);
        req_valid = 4'b0000;
        step();
        req_valid = 4'b0110;
        dif.ack = 1'b1;
        step();
        chk("t3b_ack", 64'(req_ack), 64'b0100);
        chk("t3b_last", 64'(last_grant), 64'd2);
        chk("t3b_addr", 64'(dif.req__address), 64'h1002);
        req_valid = 4'b0000;
        step();

        // requester 3 holds valid through its ack cycle
        req_valid = 4'b1000;
        step();
        chk("t4_ack", 64'(req_ack), 64'b1000);
        chk("t4_addr", 64'(dif.req__address), 64'h1003);
        step();
        chk("t4_noregrant_ack", 64'(req_ack), 64'd0);
        chk("t4_noregrant_valid", 64'(dif.req__valid), 64'd0);
        req_address[48 +: 16] = 16'h3333;
        step();
        chk("t4_new_ack", 64'(req_ack), 64'b1000);
        chk("t4_new_addr", 64'(dif.req__address), 64'h3333);
        req_valid = 4'b0000;
        step();

        // reset while presenting
        req_address[0 +: 16] = 16'h00ff;
        req_valid = 4'b0001;
        dif.ack = 1'b0;
        step();
        chk("t5_pre_addr", 64'(dif.req__address), 64'h00ff);
        req_valid = 4'b0000;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid", 64'(dif.req__valid), 64'd0);
        chk("t5_addr", 64'(dif.req__address), 64'd0);
        chk("t5_ack", 64'(req_ack), 64'd0);
        chk("t5_last", 64'(last_grant), 64'd3);
        req_valid = 4'b1111;
        step();
        chk("t5_first_ack", 64'(req_ack), 64'b0001);
        chk("t5_first_last", 64'(last_grant), 64'd0);
        req_valid = 4'b0000;
        dif.ack = 1'b1;
        step();
        chk("t5_idle", 64'(dif.req__valid), 64'd0);

        // clock enable low freezes everything
        req_valid = 4'b0010;
        dif.ack = 1'b0;
        step();
        chk("t6_pre_ack", 64'(req_ack), 64'b0010);
        clk__enable = 1'b0;
        dif.ack = 1'b1;
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t6_frz_valid", 64'(dif.req__valid), 64'd1);
            chk("t6_frz_addr", 64'(dif.req__address), 64'h1001);
            chk("t6_frz_ack", 64'(req_ack), 64'b0010);
            chk("t6_frz_last", 64'(last_grant), 64'd1);
        end
        clk__enable = 1'b1;
        step();
        chk("t6_cap_ack", 64'(req_ack), 64'b1000);
        chk("t6_cap_addr", 64'(dif.req__address), 64'h3333);
        chk("t6_cap_last", 64'(last_grant), 64'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
